// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: widths, key-schedule constants and word-level helpers.
package sm4_pkg;

    localparam int BLOCK_LENGTH   = 128;
    localparam int WORD_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 5;
    localparam int KEY_EXPAND_NUM = 32;

    // System parameter FK, FK0 in the most significant word.
    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_e;

    // Rotate a 32-bit word left by n bits (0 < n < 32).
    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Linear transform used by the key schedule.
    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    // CK_i: byte j (MSB first) is (4i+j)*7 truncated to 8 bits, so no table is needed.
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] c;
        logic [7:0]  idx;
        c = '0;
        for (int j = 0; j < 4; j++) begin
            idx = {1'b0, i, 2'(j)};
            c[31 - 8*j -: 8] = idx * 8'd7;
        end
        return c;
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 S-box: 8-bit combinational substitution, shared with the round function.
module sm4_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Table lookup by byte value.
    always_comb begin
        data_o = SBOX_TABLE[11'd2047 - {data_i, 3'b000} -: 8];
    end

endmodule

// File: rtl/key_expand.sv
// SM4 key schedule: expands a master key into 32 round keys, one per clock,
// and serves them to the round stages through combinational read ports.
module key_expand #(
    parameter int BLOCK_LENGTH   = sm4_pkg::BLOCK_LENGTH,
    parameter int WORD_WIDTH     = sm4_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH     = sm4_pkg::ADDR_WIDTH,
    parameter int KEY_EXPAND_NUM = sm4_pkg::KEY_EXPAND_NUM,
    parameter int RD_PORTS       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic [BLOCK_LENGTH-1:0]        key,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rk_addr,
    output logic [RD_PORTS*WORD_WIDTH-1:0] rk,
    output logic                           busy,
    output logic                           key_ready
);

    import sm4_pkg::*;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     iter_q, iter_d;
    logic [4*WORD_WIDTH-1:0]   kWords_q, kWords_d;
    logic                      busy_q, busy_d;
    logic                      keyReady_q, keyReady_d;
    logic                      memWrite;
    logic [WORD_WIDTH-1:0]     mem_q [KEY_EXPAND_NUM];
    logic [WORD_WIDTH-1:0]     sboxIn;
    logic [WORD_WIDTH-1:0]     sboxOut;
    logic [WORD_WIDTH-1:0]     rkNext;

    // kWords_q holds {K0, K1, K2, K3}; the new round key mixes K1..K3 with CK_i.
    assign sboxIn = kWords_q[95:64] ^ kWords_q[63:32] ^ kWords_q[31:0] ^ ck(iter_q);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sm4_sbox u_sbox (
            .data_i (sboxIn[b*8 +: 8]),
            .data_o (sboxOut[b*8 +: 8])
        );
    end

    assign rkNext = kWords_q[127:96] ^ l_prime(sboxOut);

    // Next-state logic: accept a key in IDLE, generate one round key per cycle in EXPAND.
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        kWords_d   = kWords_q;
        busy_d     = busy_q;
        keyReady_d = keyReady_q;
        memWrite   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    kWords_d   = key ^ FK;
                    iter_d     = '0;
                    keyReady_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = EXPAND;
                end
            end
            EXPAND: begin
                memWrite = 1'b1;
                kWords_d = {kWords_q[95:0], rkNext};
                iter_d   = iter_q + 1'b1;
                if (iter_q == ADDR_WIDTH'(KEY_EXPAND_NUM - 1)) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    keyReady_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and key-word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            kWords_q   <= '0;
            busy_q     <= 1'b0;
            keyReady_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            kWords_q   <= kWords_d;
            busy_q     <= busy_d;
            keyReady_q <= keyReady_d;
        end
    end

    // Round-key file, written in encryption order and cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < KEY_EXPAND_NUM; e++) begin
                mem_q[e] <= '0;
            end
        end else if (memWrite) begin
            mem_q[iter_q] <= rkNext;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_read
        assign rk[p*WORD_WIDTH +: WORD_WIDTH] = mem_q[rk_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end

    assign busy      = busy_q;
    assign key_ready = keyReady_q;

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand with four read ports and a reference key schedule.
module tb_key_expand;

    localparam int RD_PORTS = 4;
    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] FK_REF  = 128'hA3B1BAC656AA3350677D9197B27022DC;

    localparam logic [2047:0] SBOX_REF = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [127:0]  key;
    logic [19:0]   rk_addr;
    logic [127:0]  rk;
    logic          busy;
    logic          key_ready;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   refRk [32];
    logic [31:0]   modelMem [32];
    logic [127:0]  randKey;

    key_expand #(.RD_PORTS(RD_PORTS)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key       (key),
        .rk_addr   (rk_addr),
        .rk        (rk),
        .busy      (busy),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] sboxRef(input logic [7:0] x);
        return SBOX_REF[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] tPrimeRef(input logic [31:0] a);
        logic [31:0] b;
        b = {sboxRef(a[31:24]), sboxRef(a[23:16]), sboxRef(a[15:8]), sboxRef(a[7:0])};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // Textbook key schedule: K[i+4] = K[i] ^ T'(K[i+1]^K[i+2]^K[i+3]^CK[i]).
    task automatic computeSchedule(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ckv;
        for (int w = 0; w < 4; w++) begin
            k[w] = mk[127 - 32*w -: 32] ^ FK_REF[127 - 32*w -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            ckv = 32'd0;
            for (int j = 0; j < 4; j++) begin
                ckv = (ckv << 8) | 32'(((4*i + j) * 7) % 256);
            end
            k[i+4] = k[i] ^ tPrimeRef(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckv);
            refRk[i] = k[i+4];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [127:0] k, input logic r);
        key_valid = valid;
        key       = k;
        rst       = r;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b0, key, 1'b0);
        end
    endtask

    // Reads all 32 entries through the four ports, then realigns to just after an edge.
    task automatic checkMem(input string tag);
        for (int a = 0; a < 32; a += 4) begin
            rk_addr = {5'(a+3), 5'(a+2), 5'(a+1), 5'(a)};
            #1;
            for (int p = 0; p < 4; p++) begin
                checkOutput($sformatf("%s[%0d]", tag, a + p), rk[p*32 +: 32], modelMem[a+p]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key = '0;
        rk_addr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset key_ready", 32'(key_ready), 32'd0);
        for (int a = 0; a < 32; a++) modelMem[a] = 32'd0;
        checkMem("reset mem");

        // Standard vector with cycle-exact write and flag timing.
        computeSchedule(STD_KEY);
        applyStimulus(1'b1, STD_KEY, 1'b0);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("std busy before write %0d", k), 32'(busy), 32'd1);
            checkOutput($sformatf("std key_ready before write %0d", k), 32'(key_ready), 32'd0);
            rk_addr = {15'd0, 5'(k)};
            #1;
            checkOutput($sformatf("std mem[%0d] before its edge", k), rk[31:0], modelMem[k]);
            @(posedge clk);
            #1;
            modelMem[k] = refRk[k];
            checkOutput($sformatf("std mem[%0d] after its edge", k), rk[31:0], modelMem[k]);
        end
        checkOutput("std done busy", 32'(busy), 32'd0);
        checkOutput("std done key_ready", 32'(key_ready), 32'd1);
        rk_addr = {5'd7, 5'd7, 5'd31, 5'd0};
        #1;
        checkOutput("port0 addr0", rk[31:0], 32'hF12186F9);
        checkOutput("port1 addr31", rk[63:32], 32'h9124A012);
        checkOutput("port2 addr7", rk[95:64], refRk[7]);
        checkOutput("port3 addr7", rk[127:96], refRk[7]);
        rk_addr = {15'd0, 5'd1};
        #1;
        checkOutput("std mem[1]", rk[31:0], 32'h41662B61);
        checkMem("std mem");

        // Keys presented mid-expansion and on the completing edge are ignored.
        randKey = {$urandom, $urandom, $urandom, $urandom};
        computeSchedule(randKey);
        applyStimulus(1'b1, randKey, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            if (c == 10) applyStimulus(1'b1, 128'd0, 1'b0);
            else if (c == 32) applyStimulus(1'b1, ~randKey, 1'b0);
            else applyStimulus(1'b0, randKey, 1'b0);
            if (c < 32) begin
                checkOutput($sformatf("ignore busy edge %0d", c), 32'(busy), 32'd1);
                checkOutput($sformatf("ignore key_ready edge %0d", c), 32'(key_ready), 32'd0);
            end
        end
        checkOutput("ignore done key_ready", 32'(key_ready), 32'd1);
        checkOutput("ignore done busy", 32'(busy), 32'd0);
        idleCycles(1);
        checkOutput("no restart key_ready", 32'(key_ready), 32'd1);
        checkOutput("no restart busy", 32'(busy), 32'd0);
        for (int a = 0; a < 32; a++) modelMem[a] = refRk[a];
        checkMem("ignore mem");

        // Back-to-back: all-zero key right after key_ready.
        computeSchedule(128'd0);
        applyStimulus(1'b1, 128'd0, 1'b0);
        checkOutput("b2b key_ready drops", 32'(key_ready), 32'd0);
        checkOutput("b2b busy rises", 32'(busy), 32'd1);
        idleCycles(31);
        checkOutput("b2b busy edge 31", 32'(busy), 32'd1);
        idleCycles(1);
        checkOutput("b2b key_ready", 32'(key_ready), 32'd1);
        for (int a = 0; a < 32; a++) modelMem[a] = refRk[a];
        checkMem("zero key mem");

        // Reset mid-expansion wipes everything, then the standard key still works.
        computeSchedule(STD_KEY);
        applyStimulus(1'b1, STD_KEY, 1'b0);
        idleCycles(14);
        applyStimulus(1'b0, STD_KEY, 1'b1);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst key_ready", 32'(key_ready), 32'd0);
        for (int a = 0; a < 32; a++) modelMem[a] = 32'd0;
        checkMem("midrst mem");
        applyStimulus(1'b1, STD_KEY, 1'b0);
        idleCycles(32);
        checkOutput("reissue key_ready", 32'(key_ready), 32'd1);
        rk_addr = {5'd7, 5'd7, 5'd31, 5'd0};
        #1;
        checkOutput("reissue mem[0]", rk[31:0], 32'hF12186F9);
        checkOutput("reissue mem[31]", rk[63:32], 32'h9124A012);
        for (int a = 0; a < 32; a++) modelMem[a] = refRk[a];
        checkMem("reissue mem");

        // Additional random keys.
        for (int r = 0; r < 2; r++) begin
            randKey = {$urandom, $urandom, $urandom, $urandom};
            computeSchedule(randKey);
            applyStimulus(1'b1, randKey, 1'b0);
            idleCycles(32);
            checkOutput($sformatf("rand%0d key_ready", r), 32'(key_ready), 32'd1);
            for (int a = 0; a < 32; a++) modelMem[a] = refRk[a];
            checkMem($sformatf("rand%0d mem", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
